alu_exec_seq: RTL and testbench

// Sequential, parametrised execute unit for the LEGv8 datapath. Decodes OPCODE/ALU_OP into a
// 4-bit ALU control code, then computes the result and NZCV flags. Results are registered

---
 rtl/alu_exec_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_exec_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// LEGv8 execute unit: decodes ALU_OP/OPCODE, computes result and NZCV behind a
// valid/ready handshake; MUL runs as a one-bit-per-cycle shift-add sequence.
module alu_exec_seq #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [10:0]      OPCODE,
  input  logic [1:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   SHAMT,
  output logic [3:0]       CTRL,
  output logic [WIDTH-1:0] RESULT,
  output logic [3:0]       FLAGS,
  output logic             ILLEGAL,
  output logic             BUSY,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_ORR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_LSL  = 4'b0011;
  localparam logic [3:0] CTRL_LSR  = 4'b0100;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b0111;
  localparam logic [3:0] CTRL_MUL  = 4'b1000;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [3:0]       dec_ctrl_c;
  logic [WIDTH-1:0] alu_res_c;
  logic [3:0]       alu_flags_c;
  logic [WIDTH:0]   sum_ext_c;
  logic [WIDTH:0]   dif_ext_c;
  logic [WIDTH-1:0] acc_nxt_c;
  logic             in_ready_c;
  logic             accept_c;

  // ALU control decode
  always_comb begin
    dec_ctrl_c = CTRL_ILL;
    unique case (ALU_OP)
      2'b00: dec_ctrl_c = CTRL_ADD;
      2'b01: dec_ctrl_c = CTRL_PASS;
      2'b10: begin
        case (OPCODE)
          OPC_ADD: dec_ctrl_c = CTRL_ADD;
          OPC_SUB: dec_ctrl_c = CTRL_SUB;
          OPC_AND: dec_ctrl_c = CTRL_AND;
          OPC_ORR: dec_ctrl_c = CTRL_ORR;
          OPC_LSL: dec_ctrl_c = CTRL_LSL;
          OPC_LSR: dec_ctrl_c = CTRL_LSR;
          OPC_MUL: dec_ctrl_c = CTRL_MUL;
          default: dec_ctrl_c = CTRL_ILL;
        endcase
      end
      default: dec_ctrl_c = CTRL_ILL;
    endcase
  end

  assign sum_ext_c = {1'b0, A} + {1'b0, B};
  // Carry out of A + ~B + 1 is the unsigned A >= B indicator
  assign dif_ext_c = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  // Single-cycle datapath; N and Z derived from the result, C/V per op
  always_comb begin
    logic c_c;
    logic v_c;
    alu_res_c = '0;
    c_c       = 1'b0;
    v_c       = 1'b0;
    case (dec_ctrl_c)
      CTRL_ADD: begin
        alu_res_c = sum_ext_c[WIDTH-1:0];
        c_c       = sum_ext_c[WIDTH];
        v_c       = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res_c[WIDTH-1] != A[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res_c = dif_ext_c[WIDTH-1:0];
        c_c       = dif_ext_c[WIDTH];
        v_c       = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res_c[WIDTH-1] != A[WIDTH-1]);
      end
      CTRL_AND:  alu_res_c = A & B;
      CTRL_ORR:  alu_res_c = A | B;
      CTRL_PASS: alu_res_c = B;
      CTRL_LSL:  alu_res_c = A << SHAMT;
      CTRL_LSR:  alu_res_c = A >> SHAMT;
      default:   alu_res_c = '0;
    endcase
    if (dec_ctrl_c == CTRL_ILL) begin
      alu_flags_c = 4'b0100;
    end else begin
      alu_flags_c = {alu_res_c[WIDTH-1], (alu_res_c == '0), c_c, v_c};
    end
  end

  assign acc_nxt_c  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY);
  assign accept_c   = IN_VALID && in_ready_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && OUT_READY) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept_c) begin
          ctrl_d = dec_ctrl_c;
          if (dec_ctrl_c == CTRL_MUL) begin
            state_d     = S_MUL;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            acc_d       = '0;
            mcand_d     = A;
            mplier_d    = B;
            cnt_d       = '0;
          end else begin
            state_d     = S_DONE;
            result_d    = alu_res_c;
            flags_d     = alu_flags_c;
            illegal_d   = (dec_ctrl_c == CTRL_ILL);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = acc_nxt_c;
          flags_d     = {acc_nxt_c[WIDTH-1], (acc_nxt_c == '0), 2'b00};
          illegal_d   = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign IN_READY  = in_ready_c;
  assign CTRL      = ctrl_q;
  assign RESULT    = result_q;
  assign FLAGS     = flags_q;
  assign ILLEGAL   = illegal_q;
  assign BUSY      = busy_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq (WIDTH=64): directed vector table, handshake corner
// sequences, and random ops checked against an arithmetic reference model.
module tb_alu_exec_seq;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [10:0] OPCODE;
  logic [1:0]  ALU_OP;
  logic [63:0] A;
  logic [63:0] B;
  logic [5:0]  SHAMT;
  logic [3:0]  CTRL;
  logic [63:0] RESULT;
  logic [3:0]  FLAGS;
  logic        ILLEGAL;
  logic        BUSY;
  logic        OUT_VALID;
  logic        OUT_READY;

  int checks = 0;
  int errors = 0;

  alu_exec_seq #(.WIDTH(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .ALU_OP(ALU_OP), .A(A), .B(B), .SHAMT(SHAMT),
    .CTRL(CTRL), .RESULT(RESULT), .FLAGS(FLAGS), .ILLEGAL(ILLEGAL),
    .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [10:0] O_ADD = 11'b10001011000;
  localparam logic [10:0] O_SUB = 11'b11001011000;
  localparam logic [10:0] O_AND = 11'b10001010000;
  localparam logic [10:0] O_ORR = 11'b10101010000;
  localparam logic [10:0] O_LSL = 11'b11010011011;
  localparam logic [10:0] O_LSR = 11'b11010011010;
  localparam logic [10:0] O_MUL = 11'b10011011000;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [10:0] opc;
    logic [1:0]  aop;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sh;
    logic [3:0]  ctrl;
    logic [63:0] res;
    logic [3:0]  flags;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: operation semantics from plain integer arithmetic
  function automatic vec_t model(input logic [10:0] opc, input logic [1:0] aop,
                                 input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh);
    vec_t e;
    string op;
    logic [63:0] r;
    logic c, v;
    longint sa, sb, sr;
    e.opc = opc; e.aop = aop; e.a = a; e.b = b; e.sh = sh;
    e.lat = 1; e.ill = 1'b0;
    c = 1'b0; v = 1'b0; r = '0;
    sa = $signed(a); sb = $signed(b);
    if (aop == 2'b00) op = "add";
    else if (aop == 2'b01) op = "pass";
    else if (aop == 2'b11) op = "ill";
    else if (opc == O_ADD) op = "add";
    else if (opc == O_SUB) op = "sub";
    else if (opc == O_AND) op = "and";
    else if (opc == O_ORR) op = "orr";
    else if (opc == O_LSL) op = "lsl";
    else if (opc == O_LSR) op = "lsr";
    else if (opc == O_MUL) op = "mul";
    else op = "ill";
    case (op)
      "add": begin
        r = a + b; c = (r < a); sr = $signed(r);
        v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0)); e.ctrl = 4'b0010;
      end
      "sub": begin
        r = a - b; c = (a >= b); sr = $signed(r);
        v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0)); e.ctrl = 4'b0110;
      end
      "and":  begin r = a & b; e.ctrl = 4'b0000; end
      "orr":  begin r = a | b; e.ctrl = 4'b0001; end
      "lsl":  begin r = a << sh; e.ctrl = 4'b0011; end
      "lsr":  begin r = a >> sh; e.ctrl = 4'b0100; end
      "pass": begin r = b; e.ctrl = 4'b0111; end
      "mul":  begin r = a * b; e.ctrl = 4'b1000; e.lat = 65; end
      default: begin e.ctrl = 4'b1111; e.ill = 1'b1; end
    endcase
    e.res = r;
    e.flags = e.ill ? 4'b0100 : {r[63], (r == 64'd0), c, v};
    return e;
  endfunction

  // Issue one op from IDLE, wait for its result, optionally stall, then drain
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int n, lat, busy_cnt, rdy_in_busy;
    @(negedge CLK);
    OPCODE = v.opc; ALU_OP = v.aop; A = v.a; B = v.b; SHAMT = v.sh; IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 100) begin @(negedge CLK); n++; end
    chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0; busy_cnt = 0; rdy_in_busy = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (BUSY) busy_cnt++;
      if (BUSY && IN_READY) rdy_in_busy++;
    end while (!OUT_VALID && lat < 200);
    chk({tag, "_out_valid"}, 64'(OUT_VALID), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), (v.lat == 65) ? 64'd64 : 64'd0);
    chk({tag, "_ready_in_busy"}, 64'(rdy_in_busy), 64'd0);
    chk({tag, "_ctrl"}, 64'(CTRL), 64'(v.ctrl));
    chk({tag, "_result"}, RESULT, v.res);
    chk({tag, "_flags"}, 64'(FLAGS), 64'(v.flags));
    chk({tag, "_illegal"}, 64'(ILLEGAL), 64'(v.ill));
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      chk({tag, "_hold_valid"}, 64'(OUT_VALID), 64'd1);
      chk({tag, "_hold_result"}, RESULT, v.res);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk({tag, "_drained"}, 64'(OUT_VALID), 64'd0);
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] pool [5];
    pool[0] = 64'd0; pool[1] = 64'd1; pool[2] = MAXP; pool[3] = MINN; pool[4] = ONES;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [10:0] opc_pool [7];
    vec_t vr;
    int n;
    logic [63:0] held;

    opc_pool[0] = O_ADD; opc_pool[1] = O_SUB; opc_pool[2] = O_AND; opc_pool[3] = O_ORR;
    opc_pool[4] = O_LSL; opc_pool[5] = O_LSR; opc_pool[6] = O_MUL;

    //               opc    aop    a       b                 sh  ctrl     res                    flags    ill lat
    vecs.push_back('{O_ADD, 2'b10, MAXP,   64'd1,            0,  4'b0010, MINN,                  4'b1001, 0, 1});
    vecs.push_back('{O_SUB, 2'b10, 64'd5,  64'd5,            0,  4'b0110, 64'd0,                 4'b0110, 0, 1});
    vecs.push_back('{O_SUB, 2'b10, 64'd0,  64'd1,            0,  4'b0110, ONES,                  4'b1000, 0, 1});
    vecs.push_back('{O_MUL, 2'b10, 64'd3,  ONES,             0,  4'b1000, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000, 0, 65});
    vecs.push_back('{O_LSL, 2'b10, 64'd1,  64'd0,            63, 4'b0011, MINN,                  4'b1000, 0, 1});
    vecs.push_back('{O_LSL, 2'b10, 64'h1234, 64'd0,          0,  4'b0011, 64'h1234,              4'b0000, 0, 1});
    vecs.push_back('{O_LSR, 2'b10, MINN,   64'd0,            63, 4'b0100, 64'd1,                 4'b0000, 0, 1});
    vecs.push_back('{O_AND, 2'b10, 64'hF0F0, 64'h0FF0,       0,  4'b0000, 64'h00F0,              4'b0000, 0, 1});
    vecs.push_back('{O_ORR, 2'b10, 64'hF000, 64'h000F,       0,  4'b0001, 64'hF00F,              4'b0000, 0, 1});
    vecs.push_back('{11'd0, 2'b00, ONES,   64'd1,            0,  4'b0010, 64'd0,                 4'b0110, 0, 1});
    vecs.push_back('{11'd0, 2'b01, 64'd9,  64'd0,            0,  4'b0111, 64'd0,                 4'b0100, 0, 1});
    vecs.push_back('{O_ADD, 2'b11, 64'd9,  64'd9,            0,  4'b1111, 64'd0,                 4'b0100, 1, 1});
    vecs.push_back('{11'd0, 2'b10, 64'd9,  64'd9,            0,  4'b1111, 64'd0,                 4'b0100, 1, 1});

    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    OPCODE = '0; ALU_OP = '0; A = '0; B = '0; SHAMT = '0;
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_result", RESULT, 64'd0);
    chk("rst_flags_ctrl_ill", {55'd0, FLAGS, CTRL, ILLEGAL}, 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], (i % 3 == 0) ? 2 : 0, $sformatf("vec%0d", i));

    // Reset in the middle of a MUL drops it at once
    @(negedge CLK);
    OPCODE = O_MUL; ALU_OP = 2'b10; A = 64'd7; B = 64'd9; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    chk("mulrst_busy_before", 64'(BUSY), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("mulrst_busy", 64'(BUSY), 64'd0);
    chk("mulrst_out_valid", 64'(OUT_VALID), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_vec(model(O_ADD, 2'b10, 64'd2, 64'd3, 6'd0), 0, "post_rst_add");

    // MUL result stalled 5 cycles, then a queued LSL issues with no bubble
    @(negedge CLK);
    OPCODE = O_MUL; ALU_OP = 2'b10; A = 64'd3; B = ONES; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    OPCODE = O_LSL; A = 64'd1; B = 64'd0; SHAMT = 6'd63;
    n = 0;
    do begin @(negedge CLK); n++; end while (!OUT_VALID && n < 200);
    chk("stall_mul_latency", 64'(n), 64'd65);
    chk("stall_mul_result", RESULT, 64'hFFFF_FFFF_FFFF_FFFD);
    held = RESULT;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_in_ready", k), 64'(IN_READY), 64'd0);
      chk($sformatf("stall%0d_result", k), RESULT, 64'hFFFF_FFFF_FFFF_FFFD);
      chk($sformatf("stall%0d_valid", k), 64'(OUT_VALID), 64'd1);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #1;
    chk("queued_in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK);
    chk("queued_valid", 64'(OUT_VALID), 64'd1);
    chk("queued_result", RESULT, MINN);
    chk("queued_ctrl", 64'(CTRL), 64'h3);
    chk("queued_flags", 64'(FLAGS), 64'h8);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;

    // Random ops against the reference model
    for (int i = 0; i < 120; i++) begin
      logic [1:0] aop;
      logic [10:0] opc;
      int sel;
      sel = $urandom_range(0, 9);
      aop = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
      if ($urandom_range(0, 9) == 0) opc = 11'($urandom);
      else opc = opc_pool[$urandom_range(0, 6)];
      vr = model(opc, aop, rand_operand(), rand_operand(), 6'($urandom));
      run_vec(vr, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
